// File: rtl/lc3b_types.sv
// Shared LC-3b memory-path types for the physical-memory burst adapter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package lc3b_types;

  localparam int LINE_WIDTH = 128;
  localparam int BEAT_WIDTH = 64;
  localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
  localparam int BEAT_BYTES = BEAT_WIDTH / 8;
  localparam int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [15:0]           lc3b_word;
  typedef logic [LINE_WIDTH-1:0] lc3b_data;
  typedef logic [BEAT_WIDTH-1:0] lc3b_beat;
  typedef logic [IDX_W-1:0]      beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

  typedef enum logic [1:0] {
    PB_IDLE  = 2'd0,
    PB_READ  = 2'd1,
    PB_WRITE = 2'd2,
    PB_DONE  = 2'd3
  } pmem_burst_state;

  // Line-aligned base: the low nibble selects a byte within the 16-byte line.
  function automatic lc3b_word line_base(input lc3b_word addr);
    return {addr[15:4], 4'b0000};
  endfunction

  // Byte address of beat idx within the line starting at base.
  function automatic lc3b_word beat_addr(input lc3b_word base, input beat_idx_t idx);
    return base + (lc3b_word'(idx) * lc3b_word'(BEAT_BYTES));
  endfunction

endpackage

// File: rtl/pmem_burst_adapter_if.sv
// Line-side request bus and beat-side physical memory bus of the burst adapter.
// Latency: n/a (wiring only).
// Backpressure: requests are held by the requester until mem_resp; beats until pmem_resp.
interface pmem_burst_adapter_if
  import lc3b_types::*;
();

  // Line side (from the write-back buffer)
  logic      mem_read;
  logic      mem_write;
  lc3b_word  mem_address;
  lc3b_data  mem_wdata;
  logic      mem_resp;
  lc3b_data  mem_rdata;
  logic      busy;

  // Beat side (to physical memory)
  logic      pmem_read;
  logic      pmem_write;
  lc3b_word  pmem_address;
  lc3b_beat  pmem_wdata;
  lc3b_beat  pmem_rdata;
  logic      pmem_resp;

  // Environment view: issues line requests and plays physical memory.
  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, pmem_rdata, pmem_resp,
    input  mem_resp, mem_rdata, busy, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  // Adapter view.
  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, pmem_rdata, pmem_resp,
    output mem_resp, mem_rdata, busy, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/line_beat_buffer.sv
// One cache line of storage with beat-granular write, full-line load and beat read mux.
// Latency: writes visible the cycle after the edge; beat read mux is combinational.
// Backpressure: none; clear has priority over line load, which has priority over beat write.
module line_beat_buffer
  import lc3b_types::*;
(
  input  logic      clk,
  input  logic      clr_i,
  input  logic      line_we_i,
  input  lc3b_data  line_dat_i,
  input  logic      beat_we_i,
  input  beat_idx_t beat_idx_i,
  input  lc3b_beat  beat_dat_i,
  output lc3b_data  line_o,
  output lc3b_beat  beat_o
);

  lc3b_data line_q;
  lc3b_data line_d;

  // Select the next line contents from clear, parallel load or a single beat.
  always_comb begin
    line_d = line_q;
    if (clr_i) begin
      line_d = '0;
    end else if (line_we_i) begin
      line_d = line_dat_i;
    end else if (beat_we_i) begin
      line_d[beat_idx_i*BEAT_WIDTH +: BEAT_WIDTH] = beat_dat_i;
    end
  end

  // Line storage register.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign line_o = line_q;
  assign beat_o = line_q[beat_idx_i*BEAT_WIDTH +: BEAT_WIDTH];

endmodule

// File: rtl/pmem_burst_adapter.sv
// Splits 128-bit line reads/writes into 64-bit pmem beats and reassembles read lines.
// Latency: zero-wait line takes accept edge + BEATS beat cycles, mem_resp the cycle after.
// Backpressure: each beat held stable until pmem_resp; line request held until mem_resp.
module pmem_burst_adapter
  import lc3b_types::*;
(
  input  logic                 clk,
  input  logic                 reset,
  pmem_burst_adapter_if.slave  bus
);

  pmem_burst_state state_q, state_d;
  beat_idx_t       idx_q, idx_d;
  lc3b_word        base_q, base_d;
  logic            rd_q, rd_d;        // current/last line transaction was a read
  lc3b_data        rdata_q, rdata_d;  // last completed read line, held for mem_rdata

  logic     line_we;
  logic     beat_we;
  lc3b_data buf_line;
  lc3b_beat buf_beat;

  // The one buffer holds the write line during a write burst and gathers
  // beats during a read burst; rdata_q keeps the last read line visible.
  line_beat_buffer u_line_buf (
    .clk        (clk),
    .clr_i      (reset),
    .line_we_i  (line_we),
    .line_dat_i (bus.mem_wdata),
    .beat_we_i  (beat_we),
    .beat_idx_i (idx_q),
    .beat_dat_i (bus.pmem_rdata),
    .line_o     (buf_line),
    .beat_o     (buf_beat)
  );

  // State, beat counter and latched request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PB_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state: accept in IDLE (write wins), step beats on pmem_resp, DONE back to IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    line_we = 1'b0;
    beat_we = 1'b0;
    case (state_q)
      PB_IDLE: begin
        if (bus.mem_write) begin
          state_d = PB_WRITE;
          base_d  = line_base(bus.mem_address);
          idx_d   = '0;
          rd_d    = 1'b0;
          line_we = 1'b1;
        end else if (bus.mem_read) begin
          state_d = PB_READ;
          base_d  = line_base(bus.mem_address);
          idx_d   = '0;
          rd_d    = 1'b1;
        end
      end
      PB_READ, PB_WRITE: begin
        if (bus.pmem_resp) begin
          beat_we = (state_q == PB_READ);
          if (idx_q == LAST_BEAT) begin
            state_d = PB_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + beat_idx_t'(1);
          end
        end
      end
      PB_DONE: begin
        state_d = PB_IDLE;
        if (rd_q) begin
          rdata_d = buf_line;
        end
      end
      default: state_d = PB_IDLE;
    endcase
  end

  // Outputs decoded from the registered state; address/data are zero outside a burst.
  always_comb begin
    bus.mem_resp     = (state_q == PB_DONE);
    bus.busy         = (state_q != PB_IDLE);
    bus.pmem_read    = (state_q == PB_READ);
    bus.pmem_write   = (state_q == PB_WRITE);
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.mem_rdata    = rdata_q;
    if (state_q == PB_READ || state_q == PB_WRITE) begin
      bus.pmem_address = beat_addr(base_q, idx_q);
    end
    if (state_q == PB_WRITE) begin
      bus.pmem_wdata = buf_beat;
    end
    if (state_q == PB_DONE && rd_q) begin
      bus.mem_rdata = buf_line;
    end
  end

endmodule
